// File: rtl/param_save_fsm_pkg.sv
// Shared parameter-load definitions: FSM state encodings, CRC-16/CCITT constants
// and the word-wide CRC step used by the save and auto-load FSMs.
package param_save_fsm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'b000,
    ST_CLR_CRC    = 3'b001,
    ST_FETCH      = 3'b010,
    ST_WRITE      = 3'b011,
    ST_WR_CRC     = 3'b100,
    ST_START_PROG = 3'b101,
    ST_WAIT_PROG  = 3'b110,
    ST_DONE       = 3'b111
  } state_e;

  localparam logic [15:0] CRC_POLY     = 16'h1021;
  localparam logic [15:0] CRC_INIT_DEF = 16'hFFFF;

  // One 16-bit word, MSB first: fold the word into the register, then 16 shift steps.
  function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic [15:0] din);
    logic [15:0] c;
    c = crc ^ din;
    for (int unsigned i = 0; i < 16; i++) begin
      c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/param_save_fsm_if.sv
// Handshake bundle of the parameter save FSM: request/status, parameter read,
// PROM-write FIFO and programmer control.
interface param_save_fsm_if;
  logic        SAVE_REQ;
  logic        CRC_EN;
  logic [15:0] PARAM_DATA;
  logic [5:0]  PARAM_ADDR;
  logic        PARAM_RD;
  logic        PF_FULL;
  logic        PF_WR;
  logic [15:0] PF_DATA;
  logic        PROG_START;
  logic        PROG_DONE;
  logic        PROG_ERR;
  logic        BUSY;
  logic        SAVE_DONE;
  logic        SAVE_ERR;
  logic [2:0]  SV_STATE;

  modport slave (
    input  SAVE_REQ, CRC_EN, PARAM_DATA, PF_FULL, PROG_DONE, PROG_ERR,
    output PARAM_ADDR, PARAM_RD, PF_WR, PF_DATA, PROG_START, BUSY, SAVE_DONE, SAVE_ERR, SV_STATE
  );

  modport master (
    output SAVE_REQ, CRC_EN, PARAM_DATA, PF_FULL, PROG_DONE, PROG_ERR,
    input  PARAM_ADDR, PARAM_RD, PF_WR, PF_DATA, PROG_START, BUSY, SAVE_DONE, SAVE_ERR, SV_STATE
  );
endinterface

// File: rtl/param_save_fsm_crc.sv
// Registered CRC-16/CCITT accumulator: CLR loads the seed, DV folds in DIN;
// the result is visible one cycle after the strobe.
module crc16_ccitt
  import param_save_fsm_pkg::*;
#(
  parameter logic [15:0] CRC_INIT = CRC_INIT_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CLR,
  input  logic        DV,
  input  logic [15:0] DIN,
  output logic [15:0] CRC
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (CLR)     crc_d = CRC_INIT;
    else if (DV) crc_d = crc16_next(crc_q, DIN);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) crc_q <= CRC_INIT;
    else     crc_q <= crc_d;
  end

  assign CRC = crc_q;

endmodule

// File: rtl/param_save_fsm.sv
// Parameter save sequencer: copies MAX_WRDS parameter words (plus optional CRC)
// into the PROM-write FIFO, then starts the PROM programmer and reports status.
module param_save_fsm
  import param_save_fsm_pkg::*;
#(
  parameter int unsigned MAX_WRDS = 34,
  parameter logic [15:0] CRC_INIT = CRC_INIT_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  param_save_fsm_if.slave   bus
);

  localparam logic [5:0] LAST_WORD = 6'(MAX_WRDS - 1);

  state_e      state_q, state_d;
  logic [5:0]  word_cnt_q, word_cnt_d;
  logic [5:0]  param_addr_q, param_addr_d;
  logic        param_rd_q, param_rd_d;
  logic        pf_wr_q, pf_wr_d;
  logic [15:0] pf_data_q, pf_data_d;
  logic        prog_start_q, prog_start_d;
  logic        busy_q, busy_d;
  logic        save_done_q, save_done_d;
  logic        save_err_q, save_err_d;
  logic        crc_en_q, crc_en_d;
  logic        crc_settled_q, crc_settled_d;
  logic        crc_clr, crc_dv;
  logic [15:0] crc_val;

  crc16_ccitt #(.CRC_INIT(CRC_INIT)) u_crc (
    .CLK (CLK),
    .RST (RST),
    .CLR (crc_clr),
    .DV  (crc_dv),
    .DIN (bus.PARAM_DATA),
    .CRC (crc_val)
  );

  always_comb begin
    state_d       = state_q;
    word_cnt_d    = word_cnt_q;
    param_addr_d  = param_addr_q;
    param_rd_d    = 1'b0;
    pf_wr_d       = 1'b0;
    pf_data_d     = pf_data_q;
    save_err_d    = save_err_q;
    crc_en_d      = crc_en_q;
    crc_settled_d = crc_settled_q;
    crc_clr       = 1'b0;
    crc_dv        = 1'b0;

    unique case (state_q)
      ST_IDLE: if (bus.SAVE_REQ) begin
        state_d    = ST_CLR_CRC;
        save_err_d = 1'b0;
        word_cnt_d = '0;
        crc_clr    = 1'b1;
        crc_en_d   = bus.CRC_EN;
      end
      ST_CLR_CRC: state_d = ST_FETCH;
      ST_FETCH: begin
        param_addr_d = word_cnt_q;
        param_rd_d   = 1'b1;
        state_d      = ST_WRITE;
      end
      ST_WRITE: if (!bus.PF_FULL) begin
        pf_wr_d    = 1'b1;
        pf_data_d  = bus.PARAM_DATA;
        crc_dv     = 1'b1;
        word_cnt_d = word_cnt_q + 6'd1;
        if (word_cnt_q == LAST_WORD) begin
          if (crc_en_q) begin
            state_d       = ST_WR_CRC;
            crc_settled_d = 1'b0;
          end else begin
            state_d = ST_START_PROG;
          end
        end else begin
          state_d = ST_FETCH;
        end
      end
      // First cycle only lets the last data word's CRC update land.
      ST_WR_CRC: begin
        if (!crc_settled_q) begin
          crc_settled_d = 1'b1;
        end else if (!bus.PF_FULL) begin
          pf_wr_d   = 1'b1;
          pf_data_d = crc_val;
          state_d   = ST_START_PROG;
        end
      end
      ST_START_PROG: state_d = ST_WAIT_PROG;
      ST_WAIT_PROG: begin
        if (bus.PROG_ERR) begin
          save_err_d = 1'b1;
          state_d    = ST_DONE;
        end else if (bus.PROG_DONE) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: if (!bus.SAVE_REQ) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    prog_start_d = (state_q == ST_START_PROG);
    busy_d       = (state_d != ST_IDLE);
    save_done_d  = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      word_cnt_q    <= '0;
      param_addr_q  <= '0;
      param_rd_q    <= 1'b0;
      pf_wr_q       <= 1'b0;
      pf_data_q     <= '0;
      prog_start_q  <= 1'b0;
      busy_q        <= 1'b0;
      save_done_q   <= 1'b0;
      save_err_q    <= 1'b0;
      crc_en_q      <= 1'b0;
      crc_settled_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_cnt_q    <= word_cnt_d;
      param_addr_q  <= param_addr_d;
      param_rd_q    <= param_rd_d;
      pf_wr_q       <= pf_wr_d;
      pf_data_q     <= pf_data_d;
      prog_start_q  <= prog_start_d;
      busy_q        <= busy_d;
      save_done_q   <= save_done_d;
      save_err_q    <= save_err_d;
      crc_en_q      <= crc_en_d;
      crc_settled_q <= crc_settled_d;
    end
  end

  assign bus.PARAM_ADDR = param_addr_q;
  assign bus.PARAM_RD   = param_rd_q;
  assign bus.PF_WR      = pf_wr_q;
  assign bus.PF_DATA    = pf_data_q;
  assign bus.PROG_START = prog_start_q;
  assign bus.BUSY       = busy_q;
  assign bus.SAVE_DONE  = save_done_q;
  assign bus.SAVE_ERR   = save_err_q;
  assign bus.SV_STATE   = state_q;

endmodule

// File: tb/tb_param_save_fsm.sv
// Self-checking bench for param_save_fsm: parameter memory, FIFO sink, stall
// generator and programmer responder around a behavioural save model.
module tb_param_save_fsm;

  localparam int MAX_WRDS = 34;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  param_save_fsm_if bus();

  param_save_fsm #(.MAX_WRDS(MAX_WRDS), .CRC_INIT(16'hFFFF)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  logic [15:0] mem [64];
  assign bus.PARAM_DATA = mem[bus.PARAM_ADDR];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference CRC: bit-serial LFSR over the saved words, MSB first.
  function automatic logic [15:0] ref_crc();
    logic [15:0] r;
    logic        fb;
    r = 16'hFFFF;
    for (int w = 0; w < MAX_WRDS; w++)
      for (int b = 15; b >= 0; b--) begin
        fb = r[15] ^ mem[w][b];
        r  = {r[14:0], 1'b0};
        if (fb) r = r ^ 16'h1021;
      end
    return r;
  endfunction

  // Monitor: everything the DUT emits, logged with cycle stamps.
  int          cyc = 0;
  logic [15:0] wr_log [$];
  logic [5:0]  rd_log [$];
  int          n_start = 0, n_done = 0, last_wr_cyc = 0, start_cyc = 0;
  always @(posedge CLK) cyc++;
  always @(negedge CLK) begin
    if (bus.PF_WR) begin wr_log.push_back(bus.PF_DATA); last_wr_cyc = cyc; end
    if (bus.PARAM_RD) rd_log.push_back(bus.PARAM_ADDR);
    if (bus.PROG_START) begin n_start++; start_cyc = cyc; end
    if (bus.SAVE_DONE) n_done++;
  end

  // FIFO almost-full generator: scripted 5-cycle stalls and optional random noise.
  logic stall_w10 = 1'b0, stall_crc = 1'b0, rand_full = 1'b0;
  int   stall_left = 0, seg_wr = 0;
  always @(negedge CLK) begin
    if (!bus.BUSY) seg_wr = 0;
    else if (bus.PF_WR) seg_wr++;
    if (stall_w10 && bus.PARAM_RD && bus.PARAM_ADDR == 6'd10) stall_left = 5;
    if (stall_crc && bus.PF_WR && seg_wr == MAX_WRDS) stall_left = 5;
    bus.PF_FULL = (stall_left > 0) || (rand_full && $urandom_range(0, 3) == 0);
    if (stall_left > 0) stall_left--;
  end

  // Programmer responder: one-cycle reply resp_delay cycles after PROG_START.
  logic resp_err = 1'b0, resp_done = 1'b1;
  int   resp_delay = 10, resp_left = 0;
  always @(negedge CLK) begin
    bus.PROG_DONE = 1'b0;
    bus.PROG_ERR  = 1'b0;
    if (resp_left > 0) begin
      resp_left--;
      if (resp_left == 0) begin
        bus.PROG_DONE = resp_done;
        bus.PROG_ERR  = resp_err;
      end
    end
    if (bus.PROG_START) resp_left = resp_delay;
  end

  task automatic run_save(input logic cen, input logic exp_err, input int hold,
                          input logic flip, input logic extra, output logic [15:0] crc_word);
    int n0, r0, s0, d0, t, nwr;
    n0 = wr_log.size(); r0 = rd_log.size(); s0 = n_start; d0 = n_done;
    crc_word = '0;
    @(negedge CLK);
    bus.CRC_EN   = cen;
    bus.SAVE_REQ = 1'b1;
    @(negedge CLK);
    chk("accept_busy", bus.BUSY, 1);
    chk("err_cleared", bus.SAVE_ERR, 0);
    if (flip) bus.CRC_EN = ~cen;
    repeat (hold - 1) @(negedge CLK);
    bus.SAVE_REQ = 1'b0;
    if (extra) begin
      repeat (15) @(negedge CLK);
      bus.SAVE_REQ = 1'b1;
      @(negedge CLK);
      bus.SAVE_REQ = 1'b0;
    end
    for (t = 0; t < 3000 && n_done == d0; t++) @(negedge CLK);
    chk("done_seen", n_done != d0, 1);
    for (t = 0; t < 500 && bus.BUSY; t++) @(negedge CLK);
    repeat (20) @(negedge CLK);
    nwr = wr_log.size() - n0;
    chk("wr_count", nwr, MAX_WRDS + int'(cen));
    for (int i = 0; i < MAX_WRDS; i++)
      if (n0 + i < wr_log.size()) chk("data_word", wr_log[n0 + i], mem[i]);
    chk("rd_count", rd_log.size() - r0, MAX_WRDS);
    if (rd_log.size() > r0) chk("rd_first_addr", rd_log[r0], 0);
    if (cen && nwr > MAX_WRDS) begin
      crc_word = wr_log[n0 + MAX_WRDS];
      chk("crc_word", crc_word, ref_crc());
    end
    if (!cen) chk("start_latency_le2", (start_cyc - last_wr_cyc) <= 2, 1);
    chk("prog_start_count", n_start - s0, 1);
    chk("save_done_count", n_done - d0, 1);
    chk("save_err", bus.SAVE_ERR, exp_err);
    chk("idle_state", bus.SV_STATE, 0);
    chk("idle_busy", bus.BUSY, 0);
  endtask

  initial begin
    logic [15:0] crc_a, crc_b, crc_x;
    logic        cen;
    int          n0, s0, t;
    bus.SAVE_REQ = 1'b0;
    bus.CRC_EN   = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 16'(i);

    repeat (3) @(negedge CLK);
    chk("rst_state", bus.SV_STATE, 0);
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_addr", bus.PARAM_ADDR, 0);
    chk("rst_pf_data", bus.PF_DATA, 0);
    chk("rst_strobes", {bus.PF_WR, bus.PARAM_RD, bus.PROG_START, bus.SAVE_DONE, bus.SAVE_ERR}, 0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // Plain save with CRC, then without CRC.
    run_save(1'b1, 1'b0, 1, 1'b0, 1'b0, crc_a);
    run_save(1'b0, 1'b0, 1, 1'b0, 1'b0, crc_x);

    // Back-pressure at word 10 and at the CRC word.
    stall_w10 = 1'b1; stall_crc = 1'b1;
    run_save(1'b1, 1'b0, 1, 1'b0, 1'b0, crc_b);
    chk("crc_stall_same", crc_b, crc_a);
    stall_w10 = 1'b0; stall_crc = 1'b0;

    // Error and done together: error wins; next request clears it.
    resp_err = 1'b1; resp_done = 1'b1; resp_delay = 4;
    run_save(1'b1, 1'b1, 1, 1'b0, 1'b0, crc_x);
    resp_err = 1'b0; resp_done = 1'b1; resp_delay = 10;
    run_save(1'b1, 1'b0, 1, 1'b0, 1'b0, crc_x);

    // Random data, random back-pressure, CRC_EN changed mid-save, random outcome.
    rand_full = 1'b1;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
      cen        = 1'($urandom_range(0, 1));
      resp_err   = 1'($urandom_range(0, 1));
      resp_done  = ~resp_err;
      resp_delay = $urandom_range(1, 20);
      run_save(cen, resp_err, 1, 1'b1, 1'b0, crc_x);
    end
    rand_full = 1'b0; resp_err = 1'b0; resp_done = 1'b1; resp_delay = 10;
    for (int i = 0; i < 64; i++) mem[i] = 16'(i);

    // Reset in the middle of a save.
    n0 = wr_log.size();
    @(negedge CLK); bus.CRC_EN = 1'b1; bus.SAVE_REQ = 1'b1;
    @(negedge CLK); bus.SAVE_REQ = 1'b0;
    for (t = 0; t < 500 && (wr_log.size() - n0) < 20; t++) @(negedge CLK);
    chk("reach_word20", (wr_log.size() - n0) >= 20, 1);
    RST = 1'b1;
    #1;
    chk("mid_rst_state", bus.SV_STATE, 0);
    chk("mid_rst_outs", {bus.PARAM_ADDR, bus.PF_DATA, bus.PF_WR, bus.PARAM_RD, bus.PROG_START,
                         bus.BUSY, bus.SAVE_DONE, bus.SAVE_ERR}, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    n0 = wr_log.size(); s0 = n_start;
    repeat (30) @(negedge CLK);
    chk("post_rst_no_wr", wr_log.size() - n0, 0);
    chk("post_rst_no_start", n_start - s0, 0);
    run_save(1'b1, 1'b0, 1, 1'b0, 1'b0, crc_x);
    chk("restart_crc", crc_x, crc_a);

    // Held request saves once; a pulse while busy is ignored.
    run_save(1'b1, 1'b0, 200, 1'b0, 1'b0, crc_x);
    run_save(1'b1, 1'b0, 1, 1'b0, 1'b1, crc_x);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
